// File: rtl/flag_bank_arbiter.sv
// Round-robin arbiter that serialises read-modify-write requests onto a shared flag bank.
// One operation per grant; the bank is updated on the edge that closes the EXEC cycle.
module flag_bank_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                    CLK,
    input  logic                    CLRn,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [IDW-1:0]          gnt_id,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        Q
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    state_t             state, state_d;
    logic [IDW-1:0]     ptr, ptr_d;
    logic [NREQ-1:0]    gnt_d;
    logic [IDW-1:0]     gnt_id_d;
    logic               busy_d, done_d;
    logic [WIDTH-1:0]   q_d;
    logic [1:0]         lop, lop_d;
    logic [WIDTH-1:0]   ldata, ldata_d;

    logic [1:0]         op_a [NREQ];
    logic [WIDTH-1:0]   wd_a [NREQ];

    logic [IDW-1:0]     cand;
    logic [IDW-1:0]     win;
    logic               found;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_a[g] = op[2*g +: 2];
        assign wd_a[g] = wdata[WIDTH*g +: WIDTH];
    end

    // First requester at or after ptr, wrapping; the last-served index sits at ptr-1.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        gnt_d    = '0;
        gnt_id_d = gnt_id;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        q_d      = Q;
        lop_d    = lop;
        ldata_d  = ldata;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d  = EXEC;
                    lop_d    = op_a[win];
                    ldata_d  = wd_a[win];
                    gnt_d    = NREQ'(1) << win;
                    gnt_id_d = win;
                    busy_d   = 1'b1;
                    ptr_d    = IDW'((32'(win) + 32'd1) % NREQ);
                end
            end
            EXEC: begin
                state_d = IDLE;
                done_d  = 1'b1;
                case (lop)
                    OP_LOAD:   q_d = ldata;
                    OP_SET:    q_d = Q | ldata;
                    OP_CLEAR:  q_d = Q & ~ldata;
                    OP_TOGGLE: q_d = Q ^ ldata;
                    default:   q_d = Q;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Q      <= '0;
            lop    <= '0;
            ldata  <= '0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            gnt    <= gnt_d;
            gnt_id <= gnt_id_d;
            busy   <= busy_d;
            done   <= done_d;
            Q      <= q_d;
            lop    <= lop_d;
            ldata  <= ldata_d;
        end
    end

endmodule

// File: tb/tb_flag_bank_arbiter.sv
// Bench for flag_bank_arbiter: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_flag_bank_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDW   = 2;

    logic                   CLK;
    logic                   CLRn;
    logic [NREQ-1:0]        req;
    logic [2*NREQ-1:0]      op;
    logic [NREQ*WIDTH-1:0]  wdata;
    logic [NREQ-1:0]        gnt;
    logic [IDW-1:0]         gnt_id;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       Q;

    int nchk  = 0;
    int nfail = 0;

    flag_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK(CLK), .CLRn(CLRn), .req(req), .op(op), .wdata(wdata),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .done(done), .Q(Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending transaction plus an integer round-robin pointer.
    int               m_ptr  = 0;
    int               m_id   = 0;
    int               m_win;
    bit               m_pend = 1'b0;
    logic [NREQ-1:0]  m_gnt  = '0;
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_q    = '0;
    logic [1:0]       m_op   = '0;
    logic [WIDTH-1:0] m_data = '0;

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] o, input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
        case (o)
            2'd0:    return d;
            2'd1:    return q | d;
            2'd2:    return q & ~d;
            default: return q ^ d;
        endcase
    endfunction

    always @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            m_ptr = 0; m_id = 0; m_pend = 1'b0; m_gnt = '0;
            m_busy = 1'b0; m_done = 1'b0; m_q = '0;
        end else if (m_pend) begin
            m_q    = apply_op(m_op, m_q, m_data);
            m_pend = 1'b0;
            m_gnt  = '0;
            m_busy = 1'b0;
            m_done = 1'b1;
        end else begin
            m_done = 1'b0;
            m_win  = -1;
            for (int k = 0; k < int'(NREQ); k++)
                if (m_win < 0 && req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
            if (m_win >= 0) begin
                m_op   = op[2*m_win +: 2];
                m_data = wdata[WIDTH*m_win +: WIDTH];
                m_gnt  = NREQ'(1) << m_win;
                m_id   = m_win;
                m_ptr  = (m_win + 1) % NREQ;
                m_busy = 1'b1;
                m_pend = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        check("gnt",    32'(gnt),    32'(m_gnt));
        check("gnt_id", 32'(gnt_id), 32'(m_id));
        check("busy",   32'(busy),   32'(m_busy));
        check("done",   32'(done),   32'(m_done));
        check("Q",      32'(Q),      32'(m_q));
    end

    task automatic drive(input int i, input logic [1:0] o, input logic [WIDTH-1:0] d);
        req[i]             = 1'b1;
        op[2*i +: 2]       = o;
        wdata[WIDTH*i +: WIDTH] = d;
    endtask

    // Issue one request from an idle bank and check grant cycle then completion cycle.
    task automatic do_op(input int i, input logic [1:0] o, input logic [WIDTH-1:0] d,
                         input logic [WIDTH-1:0] expq, input string nm);
        drive(i, o, d);
        @(negedge CLK);
        check({nm, " gnt"},  32'(gnt),  32'(1) << i);
        check({nm, " busy"}, 32'(busy), 32'd1);
        req[i] = 1'b0;
        @(negedge CLK);
        check({nm, " Q"},    32'(Q),    32'(expq));
        check({nm, " done"}, 32'(done), 32'd1);
        check({nm, " gnt0"}, 32'(gnt),  32'd0);
    endtask

    initial begin
        CLRn  = 1'b1;
        req   = '0;
        op    = '0;
        wdata = '0;
        #1 CLRn = 1'b0;
        repeat (2) @(negedge CLK);
        CLRn = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle busy", 32'(busy), 32'd0);
        check("idle gnt",  32'(gnt),  32'd0);
        check("idle Q",    32'(Q),    32'd0);

        do_op(0, 2'd0, 8'hA5, 8'hA5, "load");
        do_op(1, 2'd1, 8'h0F, 8'hAF, "set");
        do_op(2, 2'd2, 8'hF0, 8'h0F, "clear");
        do_op(3, 2'd3, 8'hFF, 8'hF0, "toggle");

        for (int i = 0; i < int'(NREQ); i++) drive(i, 2'd3, 8'h01);
        for (int g = 0; g < 5; g++) begin
            @(negedge CLK);
            check("rr gnt", 32'(gnt), 32'(1) << (g % 4));
            @(negedge CLK);
            check("rr Q",    32'(Q),    32'(8'hF0 ^ 8'((g + 1) & 1)));
            check("rr done", 32'(done), 32'd1);
        end
        req = '0;

        do_op(2, 2'd1, 8'h00, 8'hF1, "pre-wrap");
        drive(3, 2'd0, 8'h3C);
        drive(0, 2'd3, 8'hFF);
        @(negedge CLK);
        check("wrap gnt3", 32'(gnt),    32'h8);
        check("wrap id3",  32'(gnt_id), 32'd3);
        req[3] = 1'b0;
        @(negedge CLK);
        check("wrap Q3",   32'(Q),      32'h3C);
        @(negedge CLK);
        check("wrap gnt0", 32'(gnt),    32'h1);
        check("wrap id0",  32'(gnt_id), 32'd0);
        req[0] = 1'b0;
        @(negedge CLK);
        check("wrap Q0",   32'(Q),      32'hC3);
        @(negedge CLK);
        check("id hold",   32'(gnt_id), 32'd0);

        drive(0, 2'd0, 8'h55);
        @(negedge CLK);
        check("rst busy",  32'(busy), 32'd1);
        #2 CLRn = 1'b0;
        #1;
        check("async Q",    32'(Q),      32'd0);
        check("async gnt",  32'(gnt),    32'd0);
        check("async busy", 32'(busy),   32'd0);
        check("async done", 32'(done),   32'd0);
        check("async id",   32'(gnt_id), 32'd0);
        #1 CLRn = 1'b1;
        @(negedge CLK);
        check("no done",   32'(done), 32'd0);
        check("regrant",   32'(gnt),  32'h1);
        req[0] = 1'b0;
        @(negedge CLK);
        check("reload Q",  32'(Q),    32'h55);
        check("reload dn", 32'(done), 32'd1);
        repeat (3) @(negedge CLK);
        check("quiet busy", 32'(busy), 32'd0);

        repeat (3000) begin
            @(negedge CLK);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req[i]) begin
                    if (gnt[i]) begin
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                        else drive(i, 2'($urandom), 8'($urandom));
                    end else if ($urandom_range(0, 15) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    drive(i, 2'($urandom), 8'($urandom));
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 CLRn = 1'b0;
                #1 CLRn = 1'b1;
            end
        end
        req = '0;
        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
